// File: rtl/pmem_responder.sv
// pmem_responder: line-granular physical-memory responder for the 256-bit pmem
// handshake. Accepts one read or write at a time, holds it for LATENCY cycles,
// then pulses pmem_resp for one cycle (with read data for reads).
//
// Optional feature macro: PMEM_PROTOCOL_CHECK_EN
//   defined   -> sticky pmem_err on initiator protocol violations (+ $error)
//   undefined -> pmem_err tied low, no checker logic
//
// Ports:
//   clk           in   sole clock, rising edge
//   rst_n         in   synchronous active-low reset
//   pmem_read     in   read request
//   pmem_write    in   write request (wins if both are high)
//   pmem_address  in   byte address; line index is [LINES_LOG2+4:5]
//   pmem_wdata    in   write line
//   pmem_rdata    out  read line, valid in the pmem_resp cycle of a read
//   pmem_resp     out  one-cycle completion pulse
//   pmem_err      out  sticky protocol-violation flag
module pmem_responder #(
  parameter int unsigned LINES_LOG2 = 12,
  parameter int unsigned LATENCY    = 8,
  parameter string       INIT_FILE  = ""
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_err
);

  localparam int unsigned IDX_HI   = LINES_LOG2 + 4;
  localparam int unsigned DEPTH    = 32'(1) << LINES_LOG2;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned LINE_W   = 256;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [LINES_LOG2-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0]      wdata_q, wdata_d;

  logic [LINE_W-1:0]      mem [DEPTH];

  // Offset bits and aliasing high bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pmem_address[31:IDX_HI+1], pmem_address[4:0]};

  // Next-state and request-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          op_wr_d = pmem_write;
          idx_d   = pmem_address[IDX_HI:5];
          wdata_d = pmem_wdata;
          cnt_d   = CNT_LOAD;
          state_d = (CNT_LOAD == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      pmem_resp <= (state_d == RESP);
      // Read data captured on the edge entering RESP.
      if ((state_d == RESP) && !op_wr_d) pmem_rdata <= mem[idx_d];
    end
  end

  // Write commits on the edge leaving RESP; reset on that edge discards it.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == RESP) && op_wr_q) mem[idx_q] <= wdata_q;
  end

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic viol_c;

  // Initiator must present one op in IDLE and hold it unchanged through WAIT.
  always_comb begin
    viol_c = 1'b0;
    case (state_q)
      IDLE: viol_c = pmem_read && pmem_write;
      WAIT: viol_c = (!pmem_read && !pmem_write) ||
                     (pmem_write != op_wr_q) ||
                     (pmem_address[IDX_HI:5] != idx_q);
      default: viol_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmem_err <= 1'b0;
    end else if (viol_c) begin
      pmem_err <= 1'b1;
      $error("pmem_responder: protocol violation at time %0t", $time);
    end
  end
`else
  assign pmem_err = 1'b0;
`endif

endmodule
